imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction memory writer for the single-cycle RISC-V CPU: accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and drives the instruction memory write port. The fetch path only reads instruction memory; this block fills it. It holds the CPU in reset (`cpu_hold`) until a complete image has been written, then releases it so fetch starts at PC 0.

## Interface
- `ADDR_W`, default 10: word-address width; capacity is 2^ADDR_W words.
- `CLK`  in  1  clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte-stream valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  block can accept a byte.
- `we`  out  1  one-cycle instruction memory write strobe.
- `waddr`  out  ADDR_W  word address of the write.
- `wdata`  out  32  instruction word.
- `cpu_hold`  out  1  keeps the CPU in reset while high.
- `done`  out  1  image loaded; sticky until `Reset`.
- `err`  out  1  load failed; sticky until `Reset`.
- `words_loaded`  out  ADDR_W+1  count of words written.

## Operation
- A byte transfers on a cycle where `in_valid && in_ready`. No other cycle transfers data.
- Stream format:
  - Header: N, 16-bit little-endian (low byte first).
  - Payload: 4N bytes, each word least significant byte first.
  - Checksum byte, only when the checksum feature is enabled (see Configuration).
- States:
  - HDR_LO, HDR_HI: capture N.
  - PAYLOAD: collect word bytes.
  - CHECK: checksum byte (only when enabled).
  - DONE.
  - ERR.
- `in_ready` is 1 in HDR_LO, HDR_HI, PAYLOAD and CHECK. It is 0 in DONE and ERR.
- HDR_HI transitions, decided on the accepted high byte:
  - N > 2^ADDR_W → ERR.
  - N == 0 → CHECK if enabled, else DONE.
  - Otherwise → PAYLOAD.
- PAYLOAD:
  - A 2-bit byte counter places byte k at `wdata[8k+7:8k]`.
  - On the 4th accepted byte, the word is written to address `words_loaded`, then `words_loaded` increments.
  - After word N-1 is written → CHECK if enabled, else DONE.
- Outputs by state:
  - DONE: `done`=1, `cpu_hold`=0.
  - ERR: `err`=1, `cpu_hold`=1.
  - All other states: `cpu_hold`=1.
- Memory contents are never cleared by this block.

## Timing
- Reset values:
  - `we`=0, `waddr`=0, `wdata`=0, `words_loaded`=0.
  - `cpu_hold`=1, `done`=0, `err`=0.
  - State = HDR_LO, so `in_ready`=1 from the first cycle after `Reset` deasserts.
- `in_ready` is a decode of the state register only. It never depends on `in_valid`, which prevents combinational loops.
- Write latency: `we`, `waddr` and `wdata` are registered and valid in the cycle after the 4th byte of a word is accepted. `we` is high for exactly one cycle per word.
- `done` rises the cycle after the last payload byte (or checksum byte, or header high byte when N=0) is accepted. `cpu_hold` falls in the same cycle.
- `err` rises the cycle after the offending byte is accepted.
- Gaps in `in_valid` (including between bytes of one word) stall the block without changing state or the partial word.
- N = 2^ADDR_W is legal. `words_loaded` then reaches 2^ADDR_W, and `waddr` wraps only in the internal counter after the last write.
- `Reset` mid-load: the next cycle is the reset state, and any partial word is discarded. Words already written remain in memory.
- Bytes offered while in DONE or ERR are never accepted.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - A running 8-bit XOR covers every accepted byte, header and payload included.
  - One checksum byte follows the payload; the CHECK state accepts it.
  - Checksum equal to the running XOR → DONE. Otherwise → ERR, and `cpu_hold` stays 1.
- Not defined: no CHECK state and no XOR register. The stream ends after the payload.

## Structure
- Package `imem_loader_pkg` holds:
  - the state enum (HDR_LO, HDR_HI, PAYLOAD, CHECK, DONE, ERR);
  - the header length constant (2 bytes);
  - the word byte-count constant (4).
- Sub-module `imem_word_packer` holds the 2-bit byte counter and the 32-bit shift/assemble register. It outputs `word_valid` and `word`, and clears on `Reset` or an explicit clear.

## Test plan
- Stream 0x02,0x00,0x13,0x05,0x10,0x00,0x93,0x05,0x20,0x00 (checksum disabled) → `we` at addr 0 data 0x00100513, then at addr 1 data 0x00200593; then `done`=1, `cpu_hold`=0, `words_loaded`=2, `in_ready`=0.
- Header 0x00,0x00 → `done`=1 the cycle after the second byte; no `we` pulse.
- With `ADDR_W`=4, header 0x11,0x00 (N=17) → `err`=1, `cpu_hold`=1, `in_ready`=0; no `we` pulse.
- Same stream as the first test with `in_valid` toggling 1/0 every cycle → identical writes; each `we` lands one cycle after the 4th byte of its word.
- `Reset` asserted after 2 of 4 payload bytes, then the full stream is replayed → exactly the expected words; no stale bytes in the first word.
- `IMEM_LOADER_CHECKSUM_EN` with header 0x01,0x00 and payload 0x13,0x00,0x00,0x00:
  - checksum 0x12 → `done`=1;
  - checksum 0x00 → `err`=1, `cpu_hold`=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared state encoding and stream-format constants for the imem_loader
// boot-time instruction memory writer.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      PAYLOAD,
      CHECK,
      DONE,
      ERR
   } loadState_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_word_packer.sv
// Assembles four consecutive stream bytes into one little-endian 32-bit word.
// o_word is only meaningful while o_word_valid is high.
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_clear,
   input  logic        i_byte_valid,
   input  logic [7:0]  i_byte,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [1:0]  r_cnt;
   logic [23:0] r_shift;

   // The first three bytes shift in from the top; the fourth is taken straight from the input.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_cnt   <= '0;
         r_shift <= '0;
      end else if (i_byte_valid) begin
         r_cnt   <= r_cnt + 2'd1;
         r_shift <= {i_byte, r_shift[23:8]};
      end
   end

   assign o_word_valid = i_byte_valid && (r_cnt == 2'(WORD_BYTES - 1));
   assign o_word       = {i_byte, r_shift};

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream in, word writes out, CPU held until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_in_valid,
   input  logic [7:0]        i_in_data,
   output logic              o_in_ready,
   output logic              o_we,
   output logic [ADDR_W-1:0] o_waddr,
   output logic [31:0]       o_wdata,
   output logic              o_cpu_hold,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W:0]   o_words_loaded
);

   localparam int          N_W      = 8 * HDR_BYTES;
   localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loadState_t  AFTER_PAYLOAD = CHECK;
`else
   localparam loadState_t  AFTER_PAYLOAD = DONE;
`endif

   loadState_t        r_state;
   loadState_t        w_next;
   logic [7:0]        r_nlo;
   logic [N_W-1:0]    r_n;
   logic [ADDR_W:0]   r_words;
   logic              r_we;
   logic [ADDR_W-1:0] r_waddr;
   logic [31:0]       r_wdata;
   logic              w_accept;
   logic              w_pack_valid;
   logic              w_pack_clear;
   logic              w_word_valid;
   logic [31:0]       w_word;
   logic [31:0]       w_hdr_n;
   logic              w_last;

   assign o_in_ready = (r_state == HDR_LO) || (r_state == HDR_HI) ||
                       (r_state == PAYLOAD) || (r_state == CHECK);
   assign w_accept     = i_in_valid && o_in_ready;
   assign w_pack_valid = w_accept && (r_state == PAYLOAD);
   assign w_pack_clear = (r_state != PAYLOAD);
   assign w_hdr_n      = 32'({i_in_data, r_nlo});
   assign w_last       = (32'(r_words) + 32'd1) == 32'(r_n);

   imem_word_packer u_packer (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_clear      (w_pack_clear),
      .i_byte_valid (w_pack_valid),
      .i_byte       (i_in_data),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_xor;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_xor <= '0;
      end else if (w_accept && (r_state != CHECK)) begin
         r_xor <= r_xor ^ i_in_data;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= HDR_LO;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         HDR_LO: begin
            if (w_accept) w_next = HDR_HI;
         end
         HDR_HI: begin
            if (w_accept) begin
               if (w_hdr_n > CAPACITY)   w_next = ERR;
               else if (w_hdr_n == '0)   w_next = AFTER_PAYLOAD;
               else                      w_next = PAYLOAD;
            end
         end
         PAYLOAD: begin
            if (w_word_valid && w_last) w_next = AFTER_PAYLOAD;
         end
         CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_accept) w_next = (i_in_data == r_xor) ? DONE : ERR;
`else
            w_next = ERR;
`endif
         end
         DONE:    w_next = DONE;
         ERR:     w_next = ERR;
         default: w_next = ERR;
      endcase
   end

   // The address for each write is the word count before it increments, so waddr tracks the image order.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_nlo   <= '0;
         r_n     <= '0;
         r_words <= '0;
         r_we    <= 1'b0;
         r_waddr <= '0;
         r_wdata <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_accept && (r_state == HDR_LO)) r_nlo <= i_in_data;
         if (w_accept && (r_state == HDR_HI)) r_n <= {i_in_data, r_nlo};
         if (w_word_valid) begin
            r_we    <= 1'b1;
            r_waddr <= r_words[ADDR_W-1:0];
            r_wdata <= w_word;
            r_words <= r_words + (ADDR_W + 1)'(1);
         end
      end
   end

   assign o_we           = r_we;
   assign o_waddr        = r_waddr;
   assign o_wdata        = r_wdata;
   assign o_words_loaded = r_words;
   assign o_done         = (r_state == DONE);
   assign o_err          = (r_state == ERR);
   assign o_cpu_hold     = (r_state != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: the driver queues expected writes, a negedge
// monitor pops and compares them. Build with IMEM_LOADER_CHECKSUM_EN to cover the checksum path.
module tb_imem_loader;

   localparam int ADDR_W = 4;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
      int                cycle;
   } writeExp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              inValid;
   logic [7:0]        inData;
   logic              inReady;
   logic              weOut;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              cpuHold;
   logic              doneOut;
   logic              errOut;
   logic [ADDR_W:0]   wordsLoaded;

   int          checks = 0;
   int          errors = 0;
   int          cycleCount = 0;
   writeExp_t   expQ[$];
   writeExp_t   popped;
   logic [31:0] img[$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_in_valid     (inValid),
      .i_in_data      (inData),
      .o_in_ready     (inReady),
      .o_we           (weOut),
      .o_waddr        (waddr),
      .o_wdata        (wdata),
      .o_cpu_hold     (cpuHold),
      .o_done         (doneOut),
      .o_err          (errOut),
      .o_words_loaded (wordsLoaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Every write pulse must match the oldest queued expectation, including the cycle it lands in.
   always @(negedge clk) begin
      if (weOut === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedWrite actual addr=%h data=%h expected no write", waddr, wdata);
         end else begin
            popped = expQ.pop_front();
            checkOutput("writeAddr", 32'(waddr), 32'(popped.addr));
            checkOutput("writeData", wdata, popped.data);
            checkOutput("writeCycle", 32'(cycleCount), 32'(popped.cycle));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b, input bit completesWord,
                                input logic [ADDR_W-1:0] addr, input logic [31:0] data);
      writeExp_t e;
      @(negedge clk);
      inValid = 1'b1;
      inData  = b;
      checkOutput("byteAccepted", 32'(inReady), 32'd1);
      if (completesWord) begin
         e.addr  = addr;
         e.data  = data;
         e.cycle = cycleCount + 1;
         expQ.push_back(e);
      end
      @(posedge clk);
      #1;
      inValid = 1'b0;
      inData  = 8'h00;
   endtask

   task automatic sendPlain(input logic [7:0] b);
      applyStimulus(b, 1'b0, '0, '0);
   endtask

   task automatic loadImage(input logic [31:0] words[$], input int gap);
      logic [15:0] nVal;
      logic [7:0]  b;
`ifdef IMEM_LOADER_CHECKSUM_EN
      logic [7:0]  x;
`endif
      nVal = 16'(words.size());
      sendPlain(nVal[7:0]);
      repeat (gap) @(posedge clk);
      sendPlain(nVal[15:8]);
      repeat (gap) @(posedge clk);
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = nVal[7:0] ^ nVal[15:8];
`endif
      for (int w = 0; w < words.size(); w++) begin
         for (int k = 0; k < 4; k++) begin
            b = words[w][8*k +: 8];
`ifdef IMEM_LOADER_CHECKSUM_EN
            x = x ^ b;
`endif
            applyStimulus(b, k == 3, ADDR_W'(w), words[w]);
            repeat (gap) @(posedge clk);
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      sendPlain(x);
`endif
   endtask

   task automatic applyReset();
      @(negedge clk);
      reset   = 1'b1;
      inValid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checkOutput("resetWe", 32'(weOut), 32'd0);
      checkOutput("resetWaddr", 32'(waddr), 32'd0);
      checkOutput("resetWdata", wdata, 32'd0);
      checkOutput("resetWords", 32'(wordsLoaded), 32'd0);
      checkOutput("resetHold", 32'(cpuHold), 32'd1);
      checkOutput("resetDone", 32'(doneOut), 32'd0);
      checkOutput("resetErr", 32'(errOut), 32'd0);
      checkOutput("resetReady", 32'(inReady), 32'd1);
   endtask

   task automatic checkStatus(input string tag, input bit expDone, input bit expErr,
                              input bit expHold, input bit expReady, input int expWords);
      @(negedge clk);
      checkOutput({tag, "Done"}, 32'(doneOut), 32'(expDone));
      checkOutput({tag, "Err"}, 32'(errOut), 32'(expErr));
      checkOutput({tag, "Hold"}, 32'(cpuHold), 32'(expHold));
      checkOutput({tag, "Ready"}, 32'(inReady), 32'(expReady));
      checkOutput({tag, "Words"}, 32'(wordsLoaded), 32'(expWords));
   endtask

   // Offering bytes in a terminal state must neither be accepted nor change anything.
   task automatic offerRefused(input string tag, input int expWords);
      @(negedge clk);
      inValid = 1'b1;
      inData  = 8'hAA;
      repeat (3) @(negedge clk);
      checkOutput({tag, "RefusedReady"}, 32'(inReady), 32'd0);
      checkOutput({tag, "RefusedWords"}, 32'(wordsLoaded), 32'(expWords));
      inValid = 1'b0;
      inData  = 8'h00;
   endtask

   task automatic buildTwoWordImage();
      img.delete();
      img.push_back(32'h00100513);
      img.push_back(32'h00200593);
   endtask

   initial begin
      reset   = 1'b1;
      inValid = 1'b0;
      inData  = 8'h00;
      applyReset();

      $display("[TB] two-word image, back-to-back bytes");
      buildTwoWordImage();
      loadImage(img, 0);
      checkStatus("twoWord", 1'b1, 1'b0, 1'b0, 1'b0, 2);
      offerRefused("twoWord", 2);

      $display("[TB] empty image");
      applyReset();
      img.delete();
      loadImage(img, 0);
      checkStatus("empty", 1'b1, 1'b0, 1'b0, 1'b0, 0);

      $display("[TB] oversize header N=17");
      applyReset();
      sendPlain(8'h11);
      sendPlain(8'h00);
      checkStatus("oversize", 1'b0, 1'b1, 1'b1, 1'b0, 0);
      offerRefused("oversize", 0);

      $display("[TB] two-word image, valid toggling");
      applyReset();
      buildTwoWordImage();
      loadImage(img, 1);
      checkStatus("toggle", 1'b1, 1'b0, 1'b0, 1'b0, 2);

      $display("[TB] reset mid-word then replay");
      applyReset();
      sendPlain(8'h02);
      sendPlain(8'h00);
      sendPlain(8'h13);
      sendPlain(8'h05);
      applyReset();
      buildTwoWordImage();
      loadImage(img, 0);
      checkStatus("replay", 1'b1, 1'b0, 1'b0, 1'b0, 2);

      $display("[TB] full-capacity image N=16");
      applyReset();
      img.delete();
      for (int i = 0; i < 16; i++) img.push_back(32'h11111111 * 32'(i + 1) ^ 32'h00000013);
      loadImage(img, 0);
      checkStatus("full", 1'b1, 1'b0, 1'b0, 1'b0, 16);

`ifdef IMEM_LOADER_CHECKSUM_EN
      $display("[TB] checksum good");
      applyReset();
      sendPlain(8'h01);
      sendPlain(8'h00);
      applyStimulus(8'h13, 1'b0, '0, '0);
      applyStimulus(8'h00, 1'b0, '0, '0);
      applyStimulus(8'h00, 1'b0, '0, '0);
      applyStimulus(8'h00, 1'b1, '0, 32'h00000013);
      sendPlain(8'h12);
      checkStatus("csumGood", 1'b1, 1'b0, 1'b0, 1'b0, 1);

      $display("[TB] checksum bad");
      applyReset();
      sendPlain(8'h01);
      sendPlain(8'h00);
      applyStimulus(8'h13, 1'b0, '0, '0);
      applyStimulus(8'h00, 1'b0, '0, '0);
      applyStimulus(8'h00, 1'b0, '0, '0);
      applyStimulus(8'h00, 1'b1, '0, 32'h00000013);
      sendPlain(8'h00);
      checkStatus("csumBad", 1'b0, 1'b1, 1'b1, 1'b0, 1);
`endif

      repeat (3) @(negedge clk);
      checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
